mul_pipeline: RTL and testbench

Parametrised multiply pipeline that replaces the fixed four-register multiply chain between execute and writeback. It accepts one multiply per cycle from execute, computes the RV32M MUL/MULH/MULHSU/MULHU result, and delivers it to the ROB write port after `DEPTH` cycles. Unlike the fixed chain, it honours a backend stall, supports selective age-based squash on branch mispredict as well as full exception flush, and exposes a penultimate-stage bypass tap for decode.

---
 rtl/mul_pipeline_pkg.sv | 22 ++
 rtl/defines.sv | 16 +
 rtl/mul_stage_reg.sv | 74 +++++++
 rtl/mul_pipeline.sv | 146 ++++++++++++++
 tb/tb_mul_pipeline.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pipeline_pkg.sv
// Mode decode for the multiply pipeline: operand signedness, word select and zero-result flag.
`include "defines.sv"

package mul_pipeline_pkg;

   typedef struct packed {
      logic s1_signed;
      logic s2_signed;
      logic hi;
      logic zero;
   } mode_t;

   function automatic mode_t decode_funct3(input logic [2:0] f3);
      mode_t m;
      m.zero      = f3[2];
      m.hi        = !f3[2] && (f3 != `FUNCT3_MUL);
      m.s1_signed = (f3 == `FUNCT3_MULH) || (f3 == `FUNCT3_MULHSU);
      m.s2_signed = (f3 == `FUNCT3_MULH);
      return m;
   endfunction

endpackage

// File: rtl/defines.sv
// Shared constants for the multiply pipeline: default widths, RV32M funct3 codes, modular ROB age compare.
`ifndef MUL_DEFINES_SV
`define MUL_DEFINES_SV

`define WORD_SIZE       32
`define ROB_ENTRY_WIDTH 6

`define FUNCT3_MUL    3'b000
`define FUNCT3_MULH   3'b001
`define FUNCT3_MULHSU 3'b010
`define FUNCT3_MULHU  3'b011

// True when id is strictly younger than ref_id, ages measured from head modulo 2^w.
`define AGE_YOUNGER(id, ref_id, head, w) (w'((id) - (head)) > w'((ref_id) - (head)))

`endif

// File: rtl/mul_stage_reg.sv
// One multiply pipeline register: flush beats squash beats stall; a squash kills the held
// entry when stalled, otherwise it kills the entry arriving from the previous stage.
`include "defines.sv"

module mul_stage_reg #(
   parameter int WORD_SIZE       = `WORD_SIZE,
   parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       squash_valid,
   input  logic [ROB_ENTRY_WIDTH-1:0] squash_rob_id,
   input  logic [ROB_ENTRY_WIDTH-1:0] rob_head,
   input  logic                       i_vld,
   input  logic [2*WORD_SIZE-1:0]     i_prod,
   input  logic                       i_hi,
   input  logic                       i_zero,
   input  logic [ROB_ENTRY_WIDTH-1:0] i_rob_id,
   input  logic [WORD_SIZE-1:0]       i_pc,
   output logic                       o_vld,
   output logic [2*WORD_SIZE-1:0]     o_prod,
   output logic                       o_hi,
   output logic                       o_zero,
   output logic [ROB_ENTRY_WIDTH-1:0] o_rob_id,
   output logic [WORD_SIZE-1:0]       o_pc
);

   logic                       r_vld;
   logic [2*WORD_SIZE-1:0]     r_prod;
   logic                       r_hi;
   logic                       r_zero;
   logic [ROB_ENTRY_WIDTH-1:0] r_rob_id;
   logic [WORD_SIZE-1:0]       r_pc;

   logic w_kill_in;
   logic w_kill_own;

   always_comb begin
      w_kill_in  = squash_valid && `AGE_YOUNGER(i_rob_id, squash_rob_id, rob_head, ROB_ENTRY_WIDTH);
      w_kill_own = squash_valid && `AGE_YOUNGER(r_rob_id, squash_rob_id, rob_head, ROB_ENTRY_WIDTH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld    <= 1'b0;
         r_prod   <= '0;
         r_hi     <= 1'b0;
         r_zero   <= 1'b0;
         r_rob_id <= '0;
         r_pc     <= '0;
      end else if (flush) begin
         r_vld <= 1'b0;
      end else if (stall) begin
         if (w_kill_own) r_vld <= 1'b0;
      end else begin
         r_vld    <= i_vld && !w_kill_in;
         r_prod   <= i_prod;
         r_hi     <= i_hi;
         r_zero   <= i_zero;
         r_rob_id <= i_rob_id;
         r_pc     <= i_pc;
      end
   end

   assign o_vld    = r_vld;
   assign o_prod   = r_prod;
   assign o_hi     = r_hi;
   assign o_zero   = r_zero;
   assign o_rob_id = r_rob_id;
   assign o_pc     = r_pc;

endmodule

// File: rtl/mul_pipeline.sv
// RV32M multiply pipeline, DEPTH register stages from execute to ROB writeback, one issue per cycle.
// Stall freezes all stages; flush and age-based squash act even while stalled.
`include "defines.sv"

module mul_pipeline
   import mul_pipeline_pkg::*;
#(
   parameter int WORD_SIZE       = `WORD_SIZE,
   parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
   parameter int DEPTH           = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [2:0]                 in_funct3,
   input  logic [WORD_SIZE-1:0]       in_s1,
   input  logic [WORD_SIZE-1:0]       in_s2,
   input  logic [WORD_SIZE-1:0]       in_pc,
   input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       squash_valid,
   input  logic [ROB_ENTRY_WIDTH-1:0] squash_rob_id,
   input  logic [ROB_ENTRY_WIDTH-1:0] rob_head,
   output logic                       byp_valid,
   output logic [WORD_SIZE-1:0]       byp_result,
   output logic [ROB_ENTRY_WIDTH-1:0] byp_rob_id,
   output logic                       out_valid,
   output logic [WORD_SIZE-1:0]       out_result,
   output logic [ROB_ENTRY_WIDTH-1:0] out_rob_id,
   output logic [WORD_SIZE-1:0]       out_pc,
   output logic                       busy
);

   localparam int PW = 2 * WORD_SIZE;

   mode_t                w_mode;
   logic [WORD_SIZE:0]   w_s1x;
   logic [WORD_SIZE:0]   w_s2x;
   logic [PW-1:0]        w_a;
   logic [PW-1:0]        w_b;
   logic [PW-1:0]        w_prod;
   logic                 w_kill_in0;
   logic                 w_kill_own0;

   logic                       r_vld0;
   logic [PW-1:0]              r_prod0;
   logic                       r_hi0;
   logic                       r_zero0;
   logic [ROB_ENTRY_WIDTH-1:0] r_rob0;
   logic [WORD_SIZE-1:0]       r_pc0;

   logic [DEPTH-1:0]                            w_vld;
   logic [DEPTH-1:0]                            w_hi;
   logic [DEPTH-1:0]                            w_zero;
   logic [DEPTH-1:0][PW-1:0]                    w_prod_s;
   logic [DEPTH-1:0][ROB_ENTRY_WIDTH-1:0]       w_rob;
   logic [DEPTH-1:0][WORD_SIZE-1:0]             w_pc;

   // Operands widen to WORD_SIZE+1 per mode, then sign-extend to 2*WORD_SIZE so the
   // truncated product is exact for every signedness combination.
   always_comb begin
      w_mode      = decode_funct3(in_funct3);
      w_s1x       = {w_mode.s1_signed & in_s1[WORD_SIZE-1], in_s1};
      w_s2x       = {w_mode.s2_signed & in_s2[WORD_SIZE-1], in_s2};
      w_a         = {{(WORD_SIZE-1){w_s1x[WORD_SIZE]}}, w_s1x};
      w_b         = {{(WORD_SIZE-1){w_s2x[WORD_SIZE]}}, w_s2x};
      w_prod      = w_a * w_b;
      w_kill_in0  = squash_valid && `AGE_YOUNGER(in_rob_id, squash_rob_id, rob_head, ROB_ENTRY_WIDTH);
      w_kill_own0 = squash_valid && `AGE_YOUNGER(r_rob0, squash_rob_id, rob_head, ROB_ENTRY_WIDTH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld0  <= 1'b0;
         r_prod0 <= '0;
         r_hi0   <= 1'b0;
         r_zero0 <= 1'b0;
         r_rob0  <= '0;
         r_pc0   <= '0;
      end else if (flush) begin
         r_vld0 <= 1'b0;
      end else if (stall) begin
         if (w_kill_own0) r_vld0 <= 1'b0;
      end else begin
         r_vld0  <= in_valid && !w_kill_in0;
         r_prod0 <= w_prod;
         r_hi0   <= w_mode.hi;
         r_zero0 <= w_mode.zero;
         r_rob0  <= in_rob_id;
         r_pc0   <= in_pc;
      end
   end

   assign w_vld[0]    = r_vld0;
   assign w_prod_s[0] = r_prod0;
   assign w_hi[0]     = r_hi0;
   assign w_zero[0]   = r_zero0;
   assign w_rob[0]    = r_rob0;
   assign w_pc[0]     = r_pc0;

   for (genvar g = 1; g < DEPTH; g++) begin : g_stage
      mul_stage_reg #(
         .WORD_SIZE       (WORD_SIZE),
         .ROB_ENTRY_WIDTH (ROB_ENTRY_WIDTH)
      ) u_stage (
         .clk           (clk),
         .rst           (rst),
         .stall         (stall),
         .flush         (flush),
         .squash_valid  (squash_valid),
         .squash_rob_id (squash_rob_id),
         .rob_head      (rob_head),
         .i_vld         (w_vld[g-1]),
         .i_prod        (w_prod_s[g-1]),
         .i_hi          (w_hi[g-1]),
         .i_zero        (w_zero[g-1]),
         .i_rob_id      (w_rob[g-1]),
         .i_pc          (w_pc[g-1]),
         .o_vld         (w_vld[g]),
         .o_prod        (w_prod_s[g]),
         .o_hi          (w_hi[g]),
         .o_zero        (w_zero[g]),
         .o_rob_id      (w_rob[g]),
         .o_pc          (w_pc[g])
      );
   end

   function automatic logic [WORD_SIZE-1:0] sel_word(input logic [PW-1:0] p,
                                                     input logic hi, input logic zero);
      if (zero) return '0;
      return hi ? p[PW-1:WORD_SIZE] : p[WORD_SIZE-1:0];
   endfunction

   assign byp_valid  = w_vld[DEPTH-2];
   assign byp_result = sel_word(w_prod_s[DEPTH-2], w_hi[DEPTH-2], w_zero[DEPTH-2]);
   assign byp_rob_id = w_rob[DEPTH-2];

   assign out_valid  = w_vld[DEPTH-1];
   assign out_result = sel_word(w_prod_s[DEPTH-1], w_hi[DEPTH-1], w_zero[DEPTH-1]);
   assign out_rob_id = w_rob[DEPTH-1];
   assign out_pc     = w_pc[DEPTH-1];

   assign busy = |w_vld;

endmodule

// File: tb/tb_mul_pipeline.sv
// Self-checking bench for mul_pipeline: vector table, directed stall/squash/flush/reset sequences,
// and randomized traffic checked every cycle against a transaction-level reference model.
module tb_mul_pipeline;

   localparam int W  = 32;
   localparam int RW = 4;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [2:0]    in_funct3;
   logic [W-1:0]  in_s1, in_s2, in_pc;
   logic [RW-1:0] in_rob_id;
   logic          stall, flush, squash_valid;
   logic [RW-1:0] squash_rob_id, rob_head;
   logic          byp_valid, out_valid, busy;
   logic [W-1:0]  byp_result, out_result, out_pc;
   logic [RW-1:0] byp_rob_id, out_rob_id;

   always #5 clk = ~clk;

   mul_pipeline #(.WORD_SIZE(W), .ROB_ENTRY_WIDTH(RW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_funct3(in_funct3),
      .in_s1(in_s1), .in_s2(in_s2), .in_pc(in_pc), .in_rob_id(in_rob_id),
      .stall(stall), .flush(flush), .squash_valid(squash_valid),
      .squash_rob_id(squash_rob_id), .rob_head(rob_head),
      .byp_valid(byp_valid), .byp_result(byp_result), .byp_rob_id(byp_rob_id),
      .out_valid(out_valid), .out_result(out_result), .out_rob_id(out_rob_id),
      .out_pc(out_pc), .busy(busy)
   );

   typedef struct {
      logic [RW-1:0] rob;
      logic [W-1:0]  pc;
      logic [W-1:0]  res;
      int            cnt;
   } ent_t;

   typedef struct {
      logic [2:0]   f3;
      logic [W-1:0] s1;
      logic [W-1:0] s2;
      logic [W-1:0] exp;
   } vec_t;

   ent_t          q[$];
   logic [RW-1:0] ret_ids[$];
   int            ret_cyc[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;

   function automatic logic [W-1:0] ref_mul(input logic [2:0] f3, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint     sa, sb, ua, ub;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f3)
         3'd0:    begin p = ua * ub; return p[31:0];  end
         3'd1:    begin p = sa * sb; return p[63:32]; end
         3'd2:    begin p = sa * ub; return p[63:32]; end
         3'd3:    begin p = ua * ub; return p[63:32]; end
         default: return '0;
      endcase
   endfunction

   function automatic int age(input logic [RW-1:0] id, input logic [RW-1:0] head);
      logic [RW-1:0] d;
      d = id - head;
      return int'(d);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      int oi = -1;
      int bi = -1;
      foreach (q[i]) begin
         if (q[i].cnt == D-1) oi = i;
         if (q[i].cnt == D-2) bi = i;
      end
      chk("out_valid", out_valid, oi >= 0);
      if (oi >= 0) begin
         chk("out_rob_id", out_rob_id, q[oi].rob);
         chk("out_result", out_result, q[oi].res);
         chk("out_pc", out_pc, q[oi].pc);
      end
      chk("byp_valid", byp_valid, bi >= 0);
      if (bi >= 0) begin
         chk("byp_rob_id", byp_rob_id, q[bi].rob);
         chk("byp_result", byp_result, q[bi].res);
      end
      chk("busy", busy, q.size() != 0);
      if (out_valid && !stall && !flush && !rst) begin
         ret_ids.push_back(out_rob_id);
         ret_cyc.push_back(cyc);
      end
   endtask

   task automatic model_edge();
      logic take;
      ent_t nq[$];
      ent_t e;
      cyc++;
      if (rst || flush) begin
         q.delete();
         return;
      end
      take = in_valid;
      if (squash_valid) begin
         foreach (q[i])
            if (age(q[i].rob, rob_head) <= age(squash_rob_id, rob_head)) nq.push_back(q[i]);
         q = nq;
         if (age(in_rob_id, rob_head) > age(squash_rob_id, rob_head)) take = 1'b0;
      end
      if (!stall) begin
         foreach (q[i]) q[i].cnt++;
         while (q.size() > 0 && q[0].cnt > D-1) void'(q.pop_front());
         if (take) begin
            e.rob = in_rob_id;
            e.pc  = in_pc;
            e.res = ref_mul(in_funct3, in_s1, in_s2);
            e.cnt = 0;
            q.push_back(e);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_in(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RW-1:0] rob, input logic [W-1:0] pc);
      in_valid  = 1'b1;
      in_funct3 = f3;
      in_s1     = a;
      in_s2     = b;
      in_rob_id = rob;
      in_pc     = pc;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[9];
      int   m;
      int   c0;
      tbl[0] = '{3'b000, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE};
      tbl[1] = '{3'b001, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF};
      tbl[2] = '{3'b010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF};
      tbl[3] = '{3'b011, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001};
      tbl[4] = '{3'b100, 32'hFFFF_FFFF, 32'h2, 32'h0000_0000};
      tbl[5] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      tbl[6] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      tbl[7] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      tbl[8] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};

      rst = 1'b1; in_valid = 1'b0; in_funct3 = '0; in_s1 = '0; in_s2 = '0; in_pc = '0;
      in_rob_id = '0; stall = 1'b0; flush = 1'b0; squash_valid = 1'b0;
      squash_rob_id = '0; rob_head = '0;
      #2;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_byp_valid", byp_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_out_result", out_result, 0);
      chk("reset_out_rob_id", out_rob_id, 0);
      chk("reset_out_pc", out_pc, 0);
      step(); step();
      #2 rst = 1'b0;

      // Mode table: each result must show on out_* four cycles after issue.
      for (int i = 0; i < 9; i++) begin
         set_in(tbl[i].f3, tbl[i].s1, tbl[i].s2, i[RW-1:0], 32'h1000 + 4 * i);
         step();
         in_valid = 1'b0;
         repeat (D-1) step();
         chk("tbl_valid", out_valid, 1);
         chk("tbl_result", out_result, tbl[i].exp);
         idle(1);
      end

      // Back-to-back issue of 3..6.
      m = ret_ids.size();
      for (int j = 3; j <= 6; j++) begin
         set_in(3'b011, $urandom, $urandom, j[RW-1:0], $urandom);
         step();
      end
      idle(6);
      chk("b2b_count", ret_ids.size() - m, 4);
      if (ret_ids.size() >= m + 4)
         for (int j = 0; j < 4; j++) begin
            chk("b2b_id", ret_ids[m+j], j + 3);
            chk("b2b_consecutive", ret_cyc[m+j] - ret_cyc[m], j);
         end

      // Three stall cycles while two entries are in flight.
      m  = ret_ids.size();
      c0 = cyc;
      set_in(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 4'd8, 32'h2000); step();
      set_in(3'b000, 32'h0000_0007, 32'h0000_0009, 4'd9, 32'h2004); step();
      in_valid = 1'b0; step();
      stall = 1'b1; repeat (3) step();
      stall = 1'b0;
      idle(8);
      chk("stall_count", ret_ids.size() - m, 2);
      if (ret_ids.size() >= m + 2) begin
         chk("stall_id0", ret_ids[m], 8);
         chk("stall_id1", ret_ids[m+1], 9);
         chk("stall_latency", ret_cyc[m] - c0, D + 3);
      end

      // Squash with ROB id wrap, then the same with stall held over the squash.
      for (int s = 0; s < 2; s++) begin
         rob_head = 4'd14;
         m = ret_ids.size();
         set_in(3'b000, $urandom, $urandom, 4'd15, 32'h3000); step();
         set_in(3'b001, $urandom, $urandom, 4'd0,  32'h3004); step();
         set_in(3'b010, $urandom, $urandom, 4'd1,  32'h3008); step();
         set_in(3'b011, $urandom, $urandom, 4'd2,  32'h300C);
         squash_valid = 1'b1; squash_rob_id = 4'd15; stall = (s == 1);
         step();
         squash_valid = 1'b0; in_valid = 1'b0;
         if (s == 1) step();
         stall = 1'b0;
         idle(7);
         chk("squash_count", ret_ids.size() - m, 1);
         if (ret_ids.size() >= m + 1) chk("squash_survivor", ret_ids[m], 15);
      end
      rob_head = '0;

      // Flush with four entries in flight and a new issue presented.
      m = ret_ids.size();
      for (int j = 8; j <= 11; j++) begin
         set_in(3'b001, $urandom, $urandom, j[RW-1:0], $urandom);
         step();
      end
      set_in(3'b000, 32'h5, 32'h6, 4'd12, 32'h4000);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_busy", busy, 0);
      idle(6);
      chk("flush_retired", ret_ids.size() - m, 0);

      // Asynchronous reset between edges, then a fresh issue.
      set_in(3'b001, 32'h7, 32'h8, 4'd1, 32'h5000); step();
      set_in(3'b001, 32'h9, 32'hA, 4'd2, 32'h5004); step();
      in_valid = 1'b0; step();
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      q.delete();
      step();
      #3 rst = 1'b0;
      set_in(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'h6000);
      step();
      in_valid = 1'b0;
      repeat (D-1) step();
      chk("arst_new_valid", out_valid, 1);
      chk("arst_new_rob", out_rob_id, 7);
      chk("arst_new_result", out_result, 32'hFFFF_FFFE);
      idle(2);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         in_funct3     = 3'($urandom_range(0, 7));
         in_s1         = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         in_s2         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         in_pc         = $urandom;
         in_rob_id     = 4'($urandom);
         stall         = ($urandom_range(0, 4) == 0);
         squash_valid  = ($urandom_range(0, 11) == 0);
         squash_rob_id = 4'($urandom);
         flush         = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 7) == 0) rob_head = 4'($urandom);
         step();
      end
      stall = 1'b0; flush = 1'b0; squash_valid = 1'b0;
      idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
